// File: rtl/fios_mm_sequencer.sv
// Sequencer for a FIOS Montgomery multiplier: streams operand words in, then captures result words.
// Optional completed-operation counter enabled by defining FIOS_SEQ_OP_COUNT_EN.
module fios_mm_sequencer #(
  parameter int unsigned s           = 8,
  parameter int unsigned RES_LATENCY = 20,
  parameter int unsigned RES_STRIDE  = 1,
  localparam int unsigned AW         = (s > 1) ? $clog2(s) : 1
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          abort_i,
  output logic [AW-1:0] word_addr_o,
  input  logic [16:0]   b_word_i,
  input  logic [16:0]   p_word_i,
  output logic [16:0]   b_o,
  output logic [16:0]   p_o,
  output logic          fios_input_sel_o,
  input  logic [16:0]   res_i,
  output logic [16:0]   res_word_o,
  output logic [AW-1:0] res_idx_o,
  output logic          res_valid_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [31:0]   op_count_o
);

  // Largest cyc value is reached in DONE: last capture, one trailing COLLECT cycle, then DONE.
  localparam int unsigned CycMax = RES_LATENCY + (s - 1) * RES_STRIDE + 2;
  localparam int unsigned CycW   = $clog2(CycMax + 1);
  localparam int unsigned CapW   = $clog2(s + 1);
  localparam int unsigned StrW   = (RES_STRIDE > 1) ? $clog2(RES_STRIDE) : 1;

  if (RES_LATENCY < s) begin : gen_latency_check
    $error("fios_mm_sequencer: RES_LATENCY must be >= s");
  end

  typedef enum logic [2:0] {StIdle, StFeed, StWait, StCollect, StDone} state_e;

  state_e          state_q, state_d;
  logic [CycW-1:0] cyc_q, cyc_d;
  logic [CapW-1:0] cap_cnt_q;
  logic [StrW-1:0] stride_q;
  logic            capture;
  logic [16:0]     res_word_q;
  logic [AW-1:0]   res_idx_q;
  logic            res_valid_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_i) state_d = StFeed;
      end
      StFeed: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (cyc_q == CycW'(s - 1)) begin
          state_d = (RES_LATENCY == s) ? StCollect : StWait;
        end
      end
      StWait: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (cyc_q == CycW'(RES_LATENCY - 1)) begin
          state_d = StCollect;
        end
      end
      StCollect: begin
        // Leave one cycle after the last capture so its strobe is visible before DONE.
        if (abort_i) begin
          state_d = StIdle;
        end else if (cap_cnt_q == CapW'(s)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cyc_d = cyc_q + 1'b1;
    if (state_q == StIdle || state_d == StIdle) cyc_d = '0;
  end

  always_comb begin
    busy_o           = (state_q != StIdle);
    done_o           = (state_q == StDone);
    fios_input_sel_o = (state_q == StWait) || (state_q == StCollect);
    word_addr_o      = '0;
    b_o              = '0;
    p_o              = '0;
    if (state_q == StFeed) begin
      word_addr_o = cyc_q[AW-1:0];
      b_o         = b_word_i;
      p_o         = p_word_i;
    end
  end

  // Captures happen at cyc = RES_LATENCY + j*RES_STRIDE; stride_q counts the gap between them.
  assign capture = (state_q == StCollect) && !abort_i && (stride_q == '0) &&
                   (cap_cnt_q != CapW'(s));

  always_ff @(posedge clock_i) begin
    if (reset_i || state_q != StCollect) begin
      cap_cnt_q <= '0;
      stride_q  <= '0;
    end else if (capture) begin
      cap_cnt_q <= cap_cnt_q + 1'b1;
      stride_q  <= StrW'(RES_STRIDE - 1);
    end else if (stride_q != '0) begin
      stride_q <= stride_q - 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      res_word_q  <= '0;
      res_idx_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= capture;
      if (capture) begin
        res_word_q <= res_i;
        res_idx_q  <= cap_cnt_q[AW-1:0];
      end
    end
  end

  assign res_word_o  = res_word_q;
  assign res_idx_o   = res_idx_q;
  assign res_valid_o = res_valid_q;

`ifdef FIOS_SEQ_OP_COUNT_EN
  logic [31:0] op_count_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      op_count_q <= '0;
    end else if (state_q == StDone) begin
      op_count_q <= op_count_q + 32'd1;
    end
  end

  assign op_count_o = op_count_q;
`else
  assign op_count_o = '0;
`endif

endmodule

// File: tb/tb_fios_mm_sequencer.sv
// Directed bench for fios_mm_sequencer (s=8, RES_LATENCY=20, RES_STRIDE=2) with a result scoreboard.
module tb_fios_mm_sequencer;

  localparam int S   = 8;
  localparam int RL  = 20;
  localparam int STR = 2;
`ifdef FIOS_SEQ_OP_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clock_i = 1'b0;
  logic        reset_i, start_i, abort_i;
  logic [2:0]  word_addr_o, res_idx_o;
  logic [16:0] b_word_i, p_word_i, b_o, p_o, res_i, res_word_o;
  logic        fios_input_sel_o, res_valid_o, busy_o, done_o;
  logic [31:0] op_count_o;

  int tests = 0;
  int fails = 0;
  int n_done = 0;
  logic [16:0] exp_word_q[$];
  int          exp_idx_q[$];

  fios_mm_sequencer #(.s(S), .RES_LATENCY(RL), .RES_STRIDE(STR)) dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .word_addr_o      (word_addr_o),
    .b_word_i         (b_word_i),
    .p_word_i         (p_word_i),
    .b_o              (b_o),
    .p_o              (p_o),
    .fios_input_sel_o (fios_input_sel_o),
    .res_i            (res_i),
    .res_word_o       (res_word_o),
    .res_idx_o        (res_idx_o),
    .res_valid_o      (res_valid_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .op_count_o       (op_count_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts an operation from IDLE and checks 38 cycles against a cycle-accurate model.
  // abort_c / reset_c give the cyc at which abort_i / reset_i is pulsed (-1 = never).
  task automatic run_op(input int abort_c, input int reset_c, input bit hold_start);
    bit live = 1'b1;
    bit cap_prev = 1'b0;
    bit cap;
    int c;
    start_i = 1'b1;
    abort_i = (abort_c >= 0);
    step();
    start_i = hold_start;
    abort_i = 1'b0;
    for (int k = 1; k <= 38; k++) begin
      c = k - 1;
      b_word_i = 17'($urandom);
      p_word_i = 17'($urandom);
      abort_i  = (c == abort_c);
      reset_i  = (c == reset_c);
      cap = live && !abort_i && !reset_i && c >= RL && ((c - RL) % STR) == 0 &&
            ((c - RL) / STR) < S;
      if (cap) begin
        res_i = 17'(32'h100 + (c - RL) / STR);
        exp_word_q.push_back(res_i);
        exp_idx_q.push_back((c - RL) / STR);
      end else begin
        res_i = 17'h10000 | 17'($urandom_range(0, 65535));
      end
      #1;
      check("busy", busy_o, live && k <= 37);
      check("done", done_o, live && k == 37);
      check("sel", fios_input_sel_o, live && c >= S && k <= 36);
      check("addr", word_addr_o, (live && c < S) ? c : 0);
      check("b_o", b_o, (live && c < S) ? b_word_i : 17'h0);
      check("p_o", p_o, (live && c < S) ? p_word_i : 17'h0);
      check("valid", res_valid_o, cap_prev);
      if (res_valid_o === 1'b1) begin
        check("sb_nonempty", exp_word_q.size() > 0, 1);
        if (exp_word_q.size() > 0) begin
          check("res_word", res_word_o, exp_word_q.pop_front());
          check("res_idx", res_idx_o, exp_idx_q.pop_front());
        end
      end
      if (reset_c >= 0 && c == reset_c + 1) begin
        check("rst_word", res_word_o, 0);
        check("rst_idx", res_idx_o, 0);
        check("rst_cnt", op_count_o, 0);
      end
      cap_prev = cap;
      if (abort_i || reset_i) live = 1'b0;
      step();
      abort_i = 1'b0;
      reset_i = 1'b0;
    end
  endtask

  initial begin
    reset_i  = 1'b1;
    start_i  = 1'b0;
    abort_i  = 1'b0;
    b_word_i = 17'h1abcd;
    p_word_i = 17'h05555;
    res_i    = 17'h1ffff;
    start_i  = 1'b1;
    step();
    step();
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_valid", res_valid_o, 0);
    check("rst_sel", fios_input_sel_o, 0);
    check("rst_addr", word_addr_o, 0);
    check("rst_b", b_o, 0);
    check("rst_p", p_o, 0);
    check("rst_word0", res_word_o, 0);
    check("rst_idx0", res_idx_o, 0);
    check("rst_cnt0", op_count_o, 0);
    start_i = 1'b0;
    reset_i = 1'b0;
    step();

    // Nominal run.
    run_op(-1, -1, 1'b0);
    n_done++;
    check("cnt_nominal", op_count_o, CntEn ? n_done : 0);

    // Abort at cyc 22 (start issued together with abort in IDLE).
    run_op(22, -1, 1'b0);
    check("abort_sb_empty", exp_word_q.size(), 0);
    check("cnt_abort", op_count_o, CntEn ? n_done : 0);

    // start_i held through the run: one operation, then a new FEED right after IDLE.
    run_op(-1, -1, 1'b1);
    n_done++;
    check("hold_busy", busy_o, 1);
    check("hold_addr", word_addr_o, 0);
    check("hold_sel", fios_input_sel_o, 0);
    check("cnt_hold", op_count_o, CntEn ? n_done : 0);
    start_i = 1'b0;
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("hold_abort_busy", busy_o, 0);
    check("hold_abort_done", done_o, 0);

    // Reset mid-FEED, then a fresh nominal run.
    run_op(-1, 5, 1'b0);
    n_done = 0;
    check("rst_mid_sb_empty", exp_word_q.size(), 0);

    // Counter: three complete runs plus one aborted run.
    for (int i = 0; i < 3; i++) begin
      run_op(-1, -1, 1'b0);
      n_done++;
    end
    run_op(22, -1, 1'b0);
    check("cnt_final", op_count_o, CntEn ? 3 : 0);
    check("final_sb_empty", exp_word_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fios_mm_sequencer.md
FIOS_MM_SEQUENCER -- requirements
Module: fios_mm_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter s, default 8: operand length in 17-bit words, >= 1.
REQ-003 Parameter RES_LATENCY, default 20: cycles from the first feed cycle to the first result word; SHALL be >= s, with elaboration failing otherwise.
REQ-004 Parameter RES_STRIDE, default 1: cycles between consecutive result words, >= 1.
REQ-005 clock_i  in  1  clock.
REQ-006 reset_i  in  1  synchronous active-high reset.
REQ-007 start_i  in  1  request a multiplication; sampled only in IDLE.
REQ-008 abort_i  in  1  cancel the operation in progress.
REQ-009 word_addr_o  out  $clog2(s) (min 1)  operand word index during FEED, else 0.
REQ-010 b_word_i, p_word_i  in  17 each  operand words at word_addr_o, same cycle (asynchronous read).
REQ-011 b_o, p_o  out  17 each  words to multiplier b_i/p_i; b_word_i/p_word_i in FEED, else 0.
REQ-012 fios_input_sel_o  out  1  drives multiplier FIOS_input_sel_i.
REQ-013 res_i  in  17  multiplier RES_o.
REQ-014 res_word_o  out  17  captured result word, registered.
REQ-015 res_idx_o  out  $clog2(s) (min 1)  index of res_word_o.
REQ-016 res_valid_o  out  1  one-cycle strobe per captured word; no backpressure.
REQ-017 busy_o  out  1  high in any state except IDLE.
REQ-018 done_o  out  1  one-cycle completion pulse.
REQ-019 op_count_o  out  32  completed-operation counter (see Configuration).

Function
REQ-020 The FSM SHALL have the states IDLE, FEED, WAIT, COLLECT and DONE.
REQ-021 A cycle counter cyc SHALL be 0 in the first FEED cycle and increment by 1 every cycle while busy.
REQ-022 IDLE->FEED SHALL occur on the edge after start_i=1 is sampled in IDLE; start_i in any other state is ignored.
REQ-023 FEED SHALL last exactly s cycles, with word_addr_o = cyc in each cycle (0..s-1); FEED->WAIT after cyc = s-1.
REQ-024 WAIT->COLLECT SHALL occur so that the first COLLECT cycle has cyc = RES_LATENCY; if RES_LATENCY = s, WAIT is skipped and FEED goes directly to COLLECT.
REQ-025 In COLLECT, res_i SHALL be captured at cyc = RES_LATENCY + j*RES_STRIDE for j = 0..s-1.
REQ-026 Each capture SHALL present res_word_o = res_i and res_idx_o = j, with res_valid_o = 1, on the following cycle.
REQ-027 COLLECT->DONE SHALL occur on the edge after capture j = s-1.
REQ-028 done_o SHALL be 1 for exactly the one DONE cycle, and DONE->IDLE SHALL be unconditional.
REQ-029 fios_input_sel_o SHALL be 0 in IDLE, FEED and DONE and 1 in WAIT and COLLECT.
REQ-030 res_word_o and res_idx_o SHALL hold their last captured value until the next capture.
REQ-031 abort_i = 1 in FEED, WAIT or COLLECT SHALL return the FSM to IDLE on the next edge.
REQ-032 An abort SHALL raise no done_o, SHALL raise no further res_valid_o, and SHALL clear cyc.
REQ-033 abort_i SHALL be ignored in IDLE and DONE; abort_i and start_i both high in IDLE starts an operation.

Reset
REQ-034 reset_i SHALL force state IDLE and cyc = 0, and clear busy_o, done_o, res_valid_o, fios_input_sel_o, res_word_o, res_idx_o, word_addr_o and op_count_o.
REQ-035 Reset asserted mid-operation SHALL abort the operation with no done_o or res_valid_o in the following cycle.
REQ-036 Reset SHALL take priority over start_i and abort_i.

Configuration
REQ-037 The macro FIOS_SEQ_OP_COUNT_EN SHALL control the operation counter.
REQ-038 With FIOS_SEQ_OP_COUNT_EN defined, op_count_o SHALL increment by 1 in each DONE cycle, wrap from 0xFFFFFFFF to 0, and not count aborted operations.
REQ-039 Without FIOS_SEQ_OP_COUNT_EN, op_count_o SHALL be tied to 0 and no counter register SHALL exist.

Verification (s=8, RES_LATENCY=20, RES_STRIDE=2)
REQ-040 Nominal run: start_i pulse at cycle T -> FEED for cycles T+1..T+8 with addr 0..7, res_valid_o at T+22, T+24, ..., T+36 with idx 0..7, done_o at T+37, busy_o low at T+38.
REQ-041 Data path: res_i = 0x100+j at each capture cycle -> res_word_o sequence 0x100..0x107, and b_o/p_o = 0 outside FEED.
REQ-042 Abort: abort_i at cyc=22 -> IDLE on the next edge, exactly one res_valid_o seen (idx 0), no done_o, and op_count_o unchanged.
REQ-043 Start while busy: start_i held high for the whole run -> a single operation and a single done_o, then a new FEED begins the cycle after DONE->IDLE if start_i is still high.
REQ-044 Reset: reset_i at cyc=5 -> all outputs 0 next cycle, and a later start gives a nominal run.
REQ-045 Counter: 3 complete runs plus 1 aborted run -> op_count_o = 3 with the macro defined, 0 without it.
